// File: rtl/mstat_pkg.sv
// mstat_pkg
//   Shared definitions for the multi-module status monitor:
//     ch_state_t  - per-channel ap_ctrl FSM states
//     SEL_*       - rd_sel codes for the statistics readout
//     stats_t     - per-channel statistics record. Fields are STAT_W_MAX wide.
//                   Each channel zero-extends its CNT_W/LAT_W registers into it,
//                   so the upper bits are constant and are trimmed in synthesis.
package mstat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_DONE_HOLD = 2'd2
    } ch_state_t;

    localparam logic [2:0] SEL_START   = 3'd0;
    localparam logic [2:0] SEL_DONE    = 3'd1;
    localparam logic [2:0] SEL_BUSY    = 3'd2;
    localparam logic [2:0] SEL_STALL   = 3'd3;
    localparam logic [2:0] SEL_LASTLAT = 3'd4;
    localparam logic [2:0] SEL_MAXLAT  = 3'd5;

    localparam int STAT_W_MAX = 64;

    typedef struct packed {
        logic [STAT_W_MAX-1:0] start_cnt;
        logic [STAT_W_MAX-1:0] done_cnt;
        logic [STAT_W_MAX-1:0] busy_cyc;
        logic [STAT_W_MAX-1:0] stall_cyc;
        logic [STAT_W_MAX-1:0] last_lat;
        logic [STAT_W_MAX-1:0] max_lat;
    } stats_t;

endpackage

// File: rtl/multi_module_status_monitor_if.sv
// multi_module_status_monitor_if
//   Bundles the monitored ap_ctrl handshakes and the statistics readout bus.
//   Signals:
//     ap_start/ap_ready/ap_done/ap_continue [NUM_CH] - monitored handshakes
//     rd_en, rd_ch, rd_sel                           - readout request
//     rd_data, rd_valid                              - registered readout response
//   Modports:
//     master - drives the handshakes and the readout request
//     slave  - the monitor: observes the handshakes and answers reads
interface multi_module_status_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] ap_start;
    logic [NUM_CH-1:0] ap_ready;
    logic [NUM_CH-1:0] ap_done;
    logic [NUM_CH-1:0] ap_continue;

    logic              rd_en;
    logic [CH_W-1:0]   rd_ch;
    logic [2:0]        rd_sel;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_valid;

    modport master (
        output ap_start, ap_ready, ap_done, ap_continue,
        output rd_en, rd_ch, rd_sel,
        input  rd_data, rd_valid
    );

    modport slave (
        input  ap_start, ap_ready, ap_done, ap_continue,
        input  rd_en, rd_ch, rd_sel,
        output rd_data, rd_valid
    );

endinterface

// File: rtl/mstat_channel.sv
// mstat_channel
//   One monitored ap_ctrl channel: IDLE/RUN/DONE_HOLD FSM plus its
//   saturating statistics.
//   Optional feature: define MSTAT_LATENCY_EN to build the latency timer and
//   the last/max latency registers; otherwise those fields read as 0.
//   Ports:
//     clock, reset          - clock, synchronous active-high reset
//     freeze                - hold FSM, stats and timer (monitor finished)
//     clear                 - zero the statistics (FSM and timer untouched)
//     ap_start..ap_continue - this channel's handshake
//     busy                  - registered state is RUN or DONE_HOLD
//     stats                 - statistics record, zero-extended
module mstat_channel
    import mstat_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int LAT_W = 16
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   freeze,
    input  logic   clear,
    input  logic   ap_start,
    input  logic   ap_ready,
    input  logic   ap_done,
    input  logic   ap_continue,
    output logic   busy,
    output stats_t stats
);

    ch_state_t        state, state_nxt;
    logic             start_acc;
    logic             done_acc;
    logic             hold;
    logic             occupied;
    logic [CNT_W-1:0] start_cnt, done_cnt, busy_cyc, stall_cyc;
    logic [LAT_W-1:0] last_lat, max_lat;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && v != '1) ? v + CNT_W'(1) : v;
    endfunction

    assign start_acc = ap_start & ap_ready;

    // ---- FSM: state register ----
    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_IDLE;
        else if (!freeze)
            state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:
                // ap_start alone launches; ready may arrive later.
                if (ap_start) state_nxt = ST_RUN;
            ST_RUN:
                if (ap_done) begin
                    if (!ap_continue)  state_nxt = ST_DONE_HOLD;
                    else if (start_acc) state_nxt = ST_RUN;
                    else               state_nxt = ST_IDLE;
                end
            ST_DONE_HOLD:
                if (ap_continue) state_nxt = start_acc ? ST_RUN : ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    // ---- FSM: output decodes ----
    always_comb begin
        busy     = (state == ST_RUN) || (state == ST_DONE_HOLD);
        hold     = (state == ST_DONE_HOLD);
        // In DONE_HOLD the done is already pending, so continue alone accepts it.
        done_acc = ((state == ST_RUN) && ap_done && ap_continue) ||
                   ((state == ST_DONE_HOLD) && ap_continue);
        // The launch cycle counts as busy so busy_cyc matches the latency window.
        occupied = busy || ((state == ST_IDLE) && ap_start);
    end

    // ---- counters ----
    always_ff @(posedge clock) begin
        if (reset) begin
            start_cnt <= '0;
            done_cnt  <= '0;
            busy_cyc  <= '0;
            stall_cyc <= '0;
        end else if (!freeze) begin
            if (clear) begin
                start_cnt <= '0;
                done_cnt  <= '0;
                busy_cyc  <= '0;
                stall_cyc <= '0;
            end else begin
                start_cnt <= sat_inc(start_cnt, start_acc);
                done_cnt  <= sat_inc(done_cnt, done_acc);
                busy_cyc  <= sat_inc(busy_cyc, occupied);
                stall_cyc <= sat_inc(stall_cyc, hold);
            end
        end
    end

`ifdef MSTAT_LATENCY_EN
    // tmr counts cycles since the accepted start, the start cycle being 1.
    logic [LAT_W-1:0] tmr;
    logic [LAT_W-1:0] lat_now;
    logic             timing;

    assign lat_now = (tmr == '1) ? tmr : tmr + LAT_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            tmr      <= '0;
            timing   <= 1'b0;
            last_lat <= '0;
            max_lat  <= '0;
        end else if (!freeze) begin
            // Timer ignores clear so an in-flight measurement survives it.
            if (start_acc) begin
                tmr    <= LAT_W'(1);
                timing <= 1'b1;
            end else if (done_acc) begin
                timing <= 1'b0;
            end else if (timing && tmr != '1) begin
                tmr <= tmr + LAT_W'(1);
            end

            if (clear) begin
                last_lat <= '0;
                max_lat  <= '0;
            end else if (done_acc && timing) begin
                last_lat <= lat_now;
                if (lat_now > max_lat) max_lat <= lat_now;
            end
        end
    end
`else
    assign last_lat = '0;
    assign max_lat  = '0;
`endif

    always_comb begin
        stats           = '0;
        stats.start_cnt = STAT_W_MAX'(start_cnt);
        stats.done_cnt  = STAT_W_MAX'(done_cnt);
        stats.busy_cyc  = STAT_W_MAX'(busy_cyc);
        stats.stall_cyc = STAT_W_MAX'(stall_cyc);
        stats.last_lat  = STAT_W_MAX'(last_lat);
        stats.max_lat   = STAT_W_MAX'(max_lat);
    end

endmodule

// File: rtl/multi_module_status_monitor.sv
// multi_module_status_monitor
//   Monitors NUM_CH ap_ctrl channels and exposes per-channel statistics
//   through a registered readout port.
//   Optional feature: MSTAT_LATENCY_EN enables last/max latency (sel 4/5);
//   without it those selects read 0.
//   Parameters: NUM_CH (1..16), CNT_W counter width, LAT_W latency width
//   (expected LAT_W <= CNT_W).
//   Ports:
//     clock, reset  - clock, synchronous active-high reset
//     bus (slave)   - handshakes in, rd_en/rd_ch/rd_sel in, rd_data/rd_valid out
//     finish        - sets the sticky finished flag; stats/FSMs freeze after it
//     clear         - zero all statistics
//     ch_busy       - per channel, state is RUN or DONE_HOLD
//     all_idle      - every channel in IDLE
//     finished      - sticky freeze indicator
module multi_module_status_monitor
    import mstat_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int LAT_W  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    multi_module_status_monitor_if.slave  bus,
    input  logic                          finish,
    input  logic                          clear,
    output logic [NUM_CH-1:0]             ch_busy,
    output logic                          all_idle,
    output logic                          finished
);

    stats_t           stats [NUM_CH];
    stats_t           sel_st;
    logic [CNT_W-1:0] rd_mux;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mstat_channel #(
            .CNT_W (CNT_W),
            .LAT_W (LAT_W)
        ) u_ch (
            .clock       (clock),
            .reset       (reset),
            .freeze      (finished),
            .clear       (clear),
            .ap_start    (bus.ap_start[g]),
            .ap_ready    (bus.ap_ready[g]),
            .ap_done     (bus.ap_done[g]),
            .ap_continue (bus.ap_continue[g]),
            .busy        (ch_busy[g]),
            .stats       (stats[g])
        );
    end

    assign all_idle = ~|ch_busy;

    // Out-of-range channel or unused select reads as zero.
    always_comb begin
        sel_st = '0;
        rd_mux = '0;
        if (int'(bus.rd_ch) < NUM_CH) begin
            sel_st = stats[bus.rd_ch];
            case (bus.rd_sel)
                SEL_START:   rd_mux = CNT_W'(sel_st.start_cnt);
                SEL_DONE:    rd_mux = CNT_W'(sel_st.done_cnt);
                SEL_BUSY:    rd_mux = CNT_W'(sel_st.busy_cyc);
                SEL_STALL:   rd_mux = CNT_W'(sel_st.stall_cyc);
                SEL_LASTLAT: rd_mux = CNT_W'(sel_st.last_lat);
                SEL_MAXLAT:  rd_mux = CNT_W'(sel_st.max_lat);
                default:     rd_mux = '0;
            endcase
        end
    end

    // Readout samples the registered stats, so a read coinciding with an
    // increment returns the pre-increment value. Reads keep working after finish.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            finished     <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) bus.rd_data <= rd_mux;
            if (finish)    finished    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multi_module_status_monitor.sv
module tb_multi_module_status_monitor;
    import mstat_pkg::*;

    localparam int NC   = 5;   // 3-bit rd_ch so out-of-range channels are reachable
    localparam int CW   = 4;
    localparam int LW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int LMAX = (1 << LW) - 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2;
`ifdef MSTAT_LATENCY_EN
    localparam bit LAT_ON = 1'b1;
`else
    localparam bit LAT_ON = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset, finish, clear;
    logic [NC-1:0] ch_busy;
    logic          all_idle, finished;

    multi_module_status_monitor_if #(.NUM_CH(NC), .CNT_W(CW)) bus ();

    multi_module_status_monitor #(.NUM_CH(NC), .CNT_W(CW), .LAT_W(LW)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .finish   (finish),
        .clear    (clear),
        .ch_busy  (ch_busy),
        .all_idle (all_idle),
        .finished (finished)
    );

    always #5 clock = ~clock;

    // ---- reference model: what each channel is doing, per the handshake rules ----
    int m_cnt  [NC][6];   // start, done, busy, stall, last_lat, max_lat
    int m_mode [NC];
    int m_t0   [NC];      // cycle index of the accepted start being timed
    bit m_tim  [NC];
    bit m_fin;
    int cyc;
    int npass = 0, ntot = 0;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int exp_read(input int ch, input int sel);
        if (ch >= NC || sel > 5) return 0;
        if (sel >= 4 && !LAT_ON) return 0;
        return m_cnt[ch][sel];
    endfunction

    function automatic void model_step();
        if (reset) begin
            for (int c = 0; c < NC; c++) begin
                for (int k = 0; k < 6; k++) m_cnt[c][k] = 0;
                m_mode[c] = M_IDLE;
                m_tim[c]  = 1'b0;
            end
            m_fin = 1'b0;
            return;
        end
        if (m_fin) return;
        for (int c = 0; c < NC; c++) begin
            bit sr, acc, occ, hld;
            int l;
            sr  = bus.ap_start[c] & bus.ap_ready[c];
            hld = (m_mode[c] == M_HOLD);
            acc = (m_mode[c] == M_RUN && bus.ap_done[c] && bus.ap_continue[c]) ||
                  (hld && bus.ap_continue[c]);
            occ = (m_mode[c] != M_IDLE) || bus.ap_start[c];
            if (clear) begin
                for (int k = 0; k < 6; k++) m_cnt[c][k] = 0;
            end else begin
                m_cnt[c][0] = sat(m_cnt[c][0] + int'(sr), CMAX);
                m_cnt[c][1] = sat(m_cnt[c][1] + int'(acc), CMAX);
                m_cnt[c][2] = sat(m_cnt[c][2] + int'(occ), CMAX);
                m_cnt[c][3] = sat(m_cnt[c][3] + int'(hld), CMAX);
                if (acc && m_tim[c]) begin
                    l = sat(cyc - m_t0[c] + 1, LMAX);
                    m_cnt[c][4] = l;
                    if (l > m_cnt[c][5]) m_cnt[c][5] = l;
                end
            end
            if (acc) m_tim[c] = 1'b0;
            if (sr) begin
                m_tim[c] = 1'b1;
                m_t0[c]  = cyc;
            end
            case (m_mode[c])
                M_IDLE: if (bus.ap_start[c]) m_mode[c] = M_RUN;
                M_RUN:  if (bus.ap_done[c])
                            m_mode[c] = !bus.ap_continue[c] ? M_HOLD : (sr ? M_RUN : M_IDLE);
                default: if (bus.ap_continue[c]) m_mode[c] = sr ? M_RUN : M_IDLE;
            endcase
        end
        if (finish) m_fin = 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // One clock: inputs already driven; outputs checked #1 after the edge.
    task automatic step();
        int            exp_rd;
        bit            ren, rst;
        logic [NC-1:0] eb;
        ren    = bus.rd_en;
        rst    = reset;
        exp_rd = exp_read(int'(bus.rd_ch), int'(bus.rd_sel));
        @(posedge clock);
        #1;
        model_step();
        cyc++;
        if (rst) begin
            check("rst_rd_valid", 32'(bus.rd_valid), 0);
            check("rst_rd_data", 32'(bus.rd_data), 0);
        end else begin
            check("rd_valid", 32'(bus.rd_valid), 32'(ren));
            if (ren) check("rd_data", 32'(bus.rd_data), exp_rd);
        end
        for (int c = 0; c < NC; c++) eb[c] = (m_mode[c] != M_IDLE);
        check("ch_busy", 32'(ch_busy), 32'(eb));
        check("all_idle", 32'(all_idle), 32'(eb == '0));
        check("finished", 32'(finished), 32'(m_fin));
    endtask

    task automatic quiet();
        bus.ap_start = '0; bus.ap_ready = '0; bus.ap_done = '0; bus.ap_continue = '0;
    endtask

    task automatic drive(input int c, input bit s, input bit d, input bit k);
        bus.ap_start[c] = s; bus.ap_ready[c] = s; bus.ap_done[c] = d; bus.ap_continue[c] = k;
    endtask

    task automatic rd_check(input string tag, input int ch, input int sel, input int exp);
        bus.rd_en = 1'b1; bus.rd_ch = 3'(ch); bus.rd_sel = 3'(sel);
        step();
        check(tag, 32'(bus.rd_data), exp);
        bus.rd_en = 1'b0;
    endtask

    // Protocol-conformant random handshakes: done held until continue.
    task automatic rand_drive();
        bit s, d, k;
        for (int c = 0; c < NC; c++) begin
            s = 1'b0; d = 1'b0; k = 1'($urandom_range(0, 1));
            case (m_mode[c])
                M_IDLE: s = ($urandom_range(0, 2) == 0);
                M_RUN: begin
                    d = ($urandom_range(0, 3) == 0);
                    if (d && k) s = 1'($urandom_range(0, 1));
                end
                default: begin
                    d = 1'b1;
                    k = ($urandom_range(0, 2) == 0);
                    if (k) s = 1'($urandom_range(0, 1));
                end
            endcase
            drive(c, s, d, k);
        end
        clear      = ($urandom_range(0, 24) == 0);
        reset      = ($urandom_range(0, 99) == 0);
        bus.rd_en  = 1'($urandom_range(0, 1));
        bus.rd_ch  = 3'($urandom_range(0, 7));
        bus.rd_sel = 3'($urandom_range(0, 7));
    endtask

    initial begin
        int saved;
        cyc = 0;
        reset = 1'b1; finish = 1'b0; clear = 1'b0;
        quiet();
        bus.rd_en = 1'b0; bus.rd_ch = '0; bus.rd_sel = '0;
        repeat (3) step();
        check("reset_all_idle", 32'(all_idle), 1);
        check("reset_ch_busy", 32'(ch_busy), 0);
        check("reset_finished", 32'(finished), 0);
        reset = 1'b0;
        step();
        rd_check("reset_start_cnt", 0, 0, 0);

        // ch0 single transaction: start, 3 cycles, done
        drive(0, 1, 0, 0); step(); quiet();
        repeat (3) step();
        drive(0, 0, 1, 1); step(); quiet();
        rd_check("c0_start", 0, 0, 1);
        rd_check("c0_done", 0, 1, 1);
        rd_check("c0_busy", 0, 2, 5);
        rd_check("c0_stall", 0, 3, 0);
        rd_check("c0_lastlat", 0, 4, LAT_ON ? 5 : 0);
        rd_check("c0_maxlat", 0, 5, LAT_ON ? 5 : 0);

        // ch1 done held off by continue for 3 cycles
        drive(1, 1, 0, 0); step(); quiet();
        repeat (2) step();
        drive(1, 0, 1, 0); step();
        step();
        check("c1_hold_busy", 32'(ch_busy[1]), 1);
        rd_check("c1_done_pending", 1, 1, 0);
        drive(1, 0, 1, 1); step(); quiet();
        check("c1_idle_after", 32'(ch_busy[1]), 0);
        rd_check("c1_stall", 1, 3, 3);
        rd_check("c1_done", 1, 1, 1);
        rd_check("c1_lastlat", 1, 4, LAT_ON ? 7 : 0);

        // ch2 back-to-back: done+continue with start+ready in one cycle
        drive(2, 1, 0, 0); step(); quiet();
        repeat (2) step();
        drive(2, 1, 1, 1); step(); quiet();
        check("c2_b2b_busy0", 32'(ch_busy[2]), 1);
        step();
        check("c2_b2b_busy1", 32'(ch_busy[2]), 1);
        drive(2, 0, 1, 1); step(); quiet();
        rd_check("c2_start", 2, 0, 2);
        rd_check("c2_done", 2, 1, 2);
        rd_check("c2_busy", 2, 2, 6);
        rd_check("c2_lastlat", 2, 4, LAT_ON ? 3 : 0);
        rd_check("c2_maxlat", 2, 5, LAT_ON ? 4 : 0);

        // ch3: 20 starts saturate the 4-bit counters
        drive(3, 1, 0, 0); step();
        repeat (19) begin drive(3, 1, 1, 1); step(); end
        drive(3, 0, 1, 1); step(); quiet();
        rd_check("c3_start_sat", 3, 0, 15);
        rd_check("c3_done_sat", 3, 1, 15);
        rd_check("c3_lastlat", 3, 4, LAT_ON ? 2 : 0);

        // clear coincident with a ch0 start; timer keeps running
        clear = 1'b1; drive(0, 1, 0, 0); step(); clear = 1'b0; quiet();
        rd_check("clr_start", 0, 0, 0);
        rd_check("clr_other", 3, 0, 0);
        drive(0, 0, 1, 1); step(); quiet();
        rd_check("clr_done", 0, 1, 1);
        rd_check("clr_lastlat", 0, 4, LAT_ON ? 4 : 0);

        // randomized traffic against the model
        repeat (400) step_rand();
        reset = 1'b0; clear = 1'b0; bus.rd_en = 1'b0; quiet();
        repeat (2) step();

        // finish freezes stats, readout still answers
        saved = m_cnt[0][0];
        finish = 1'b1; step(); finish = 1'b0;
        check("fin_flag", 32'(finished), 1);
        drive(0, 1, 0, 0);
        repeat (3) step();
        quiet();
        rd_check("fin_start_frozen", 0, 0, saved);
        rd_check("oob_ch7", 7, 0, 0);
        check("oob_ch7_valid", 32'(bus.rd_valid), 1);
        rd_check("oob_ch5", 5, 2, 0);
        rd_check("sel6", 1, 6, 0);
        rd_check("sel7", 2, 7, 0);
        check("fin_sticky", 32'(finished), 1);

        // reset beats clear, finish and rd_en
        reset = 1'b1; clear = 1'b1; finish = 1'b1; bus.rd_en = 1'b1;
        step();
        check("rst_prio_finished", 32'(finished), 0);
        check("rst_prio_idle", 32'(all_idle), 1);
        reset = 1'b0; clear = 1'b0; finish = 1'b0; bus.rd_en = 1'b0;
        step();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    task automatic step_rand();
        rand_drive();
        step();
    endtask

endmodule
